// File: rtl/alu_seq_w.sv
// Multi-cycle sequential ALU: operands arrive serially on inbus, MUL (Booth radix-2) and
// DIV (restoring) iterate once per clock, results return as one or two words on outbus.
module alu_seq_w #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   s,
  input  logic [W-1:0] inbus,
  output logic [W-1:0] outbus,
  output logic         out_valid,
  output logic         finish,
  output logic         busy,
  output logic         negative,
  output logic         zero,
  output logic         carry,
  output logic         overflow
);

  localparam int unsigned CntW = $clog2(W) + 1;
  localparam int unsigned AccW = 2 * W + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpMul = 3'b010;
  localparam logic [2:0] OpDiv = 3'b011;
  localparam logic [2:0] OpAnd = 3'b100;
  localparam logic [2:0] OpOr  = 3'b101;
  localparam logic [2:0] OpXor = 3'b110;
  localparam logic [2:0] OpCmp = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StExec,
    StOutLo,
    StOutHi
  } state_e;

  state_e          state_q;
  logic [2:0]      op_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [AccW-1:0] acc_q;
  logic [CntW-1:0] cnt_q;
  logic [W-1:0]    outbus_q;
  logic            out_valid_q;
  logic            finish_q;
  logic            busy_q;
  logic            n_q;
  logic            z_q;
  logic            c_q;
  logic            v_q;

  logic multi_cycle;
  assign multi_cycle = (op_q == OpMul) || (op_q == OpDiv);

  // Booth step: acc = {upper[W-1:0], multiplier[W-1:0], q_-1}. The add is done one bit wider
  // so that subtracting the most negative multiplicand cannot wrap before the shift.
  logic [W:0]      a_ext;
  logic [W:0]      booth_up;
  logic [W:0]      booth_sum;
  logic [AccW-1:0] booth_next;

  always_comb begin
    a_ext    = {a_q[W-1], a_q};
    booth_up = {acc_q[2*W], acc_q[2*W:W+1]};
    unique case (acc_q[1:0])
      2'b01:   booth_sum = booth_up + a_ext;
      2'b10:   booth_sum = booth_up - a_ext;
      default: booth_sum = booth_up;
    endcase
    booth_next = {booth_sum, acc_q[W:1]};
  end

  // Restoring divide step: acc = {remainder[W:0], dividend/quotient[W-1:0]}.
  logic [W:0]      rem_sh;
  logic [W:0]      b_wide;
  logic [AccW-1:0] div_next;

  always_comb begin
    rem_sh = acc_q[2*W-1:W-1];
    b_wide = {1'b0, b_q};
    if (rem_sh >= b_wide) begin
      div_next = {rem_sh - b_wide, acc_q[W-2:0], 1'b1};
    end else begin
      div_next = {rem_sh, acc_q[W-2:0], 1'b0};
    end
  end

  logic [W:0]     add_full;
  logic [W:0]     sub_full;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quot;
  logic [W-1:0]   rem;
  logic [W-1:0]   flag_val;
  logic [W-1:0]   res_lo;
  logic [W-1:0]   res_hi;
  logic           flag_n;
  logic           flag_z;
  logic           flag_c;
  logic           flag_v;

  assign add_full = {1'b0, a_q} + {1'b0, b_q};
  assign sub_full = {1'b0, a_q} - {1'b0, b_q};
  assign prod     = acc_q[2*W:1];
  assign quot     = acc_q[W-1:0];
  assign rem      = acc_q[2*W-1:W];

  always_comb begin
    flag_val = '0;
    res_lo   = '0;
    res_hi   = '0;
    flag_n   = 1'b0;
    flag_z   = 1'b0;
    flag_c   = 1'b0;
    flag_v   = 1'b0;
    unique case (op_q)
      OpAdd: begin
        flag_val = add_full[W-1:0];
        res_lo   = flag_val;
        flag_c   = add_full[W];
        flag_v   = (a_q[W-1] == b_q[W-1]) && (add_full[W-1] != a_q[W-1]);
      end
      OpSub, OpCmp: begin
        flag_val = sub_full[W-1:0];
        res_lo   = (op_q == OpCmp) ? '0 : flag_val;
        flag_c   = sub_full[W];
        flag_v   = (a_q[W-1] != b_q[W-1]) && (sub_full[W-1] != a_q[W-1]);
      end
      OpMul: begin
        res_lo = prod[W-1:0];
        res_hi = prod[2*W-1:W];
        flag_n = prod[2*W-1];
        flag_z = ~|prod;
        // Fits in W signed bits only if the top W+1 bits are all sign copies.
        flag_v = ~((&prod[2*W-1:W-1]) | (~|prod[2*W-1:W-1]));
      end
      OpDiv: begin
        res_lo = quot;
        res_hi = rem;
        flag_n = quot[W-1];
        flag_z = ~|quot;
        flag_v = ~|b_q;
      end
      OpAnd: begin
        flag_val = a_q & b_q;
        res_lo   = flag_val;
      end
      OpOr: begin
        flag_val = a_q | b_q;
        res_lo   = flag_val;
      end
      OpXor: begin
        flag_val = a_q ^ b_q;
        res_lo   = flag_val;
      end
      default: ;
    endcase
    if (!multi_cycle) begin
      flag_n = flag_val[W-1];
      flag_z = ~|flag_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      outbus_q    <= '0;
      out_valid_q <= 1'b0;
      finish_q    <= 1'b0;
      busy_q      <= 1'b0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
    end else begin
      outbus_q    <= '0;
      out_valid_q <= 1'b0;
      finish_q    <= 1'b0;
      // Registered one cycle behind the state so it spans exactly t+1 .. last output word.
      busy_q      <= (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q    <= s;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            state_q <= StLoadA;
          end
        end
        StLoadA: begin
          a_q     <= inbus;
          state_q <= StLoadB;
        end
        StLoadB: begin
          b_q   <= inbus;
          cnt_q <= '0;
          if (op_q == OpDiv) begin
            acc_q <= {{(W + 1){1'b0}}, a_q};
          end else begin
            acc_q <= {{W{1'b0}}, inbus, 1'b0};
          end
          state_q <= StExec;
        end
        StExec: begin
          if (multi_cycle) begin
            acc_q <= (op_q == OpMul) ? booth_next : div_next;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
              state_q <= StOutLo;
            end
          end else begin
            state_q <= StOutLo;
          end
        end
        StOutLo: begin
          outbus_q    <= res_lo;
          out_valid_q <= 1'b1;
          finish_q    <= ~multi_cycle;
          n_q         <= flag_n;
          z_q         <= flag_z;
          c_q         <= flag_c;
          v_q         <= flag_v;
          state_q     <= multi_cycle ? StOutHi : StIdle;
        end
        StOutHi: begin
          outbus_q    <= res_hi;
          out_valid_q <= 1'b1;
          finish_q    <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign outbus    = outbus_q;
  assign out_valid = out_valid_q;
  assign finish    = finish_q;
  assign busy      = busy_q;
  assign negative  = n_q;
  assign zero      = z_q;
  assign carry     = c_q;
  assign overflow  = v_q;

endmodule

// File: tb/tb_alu_seq_w.sv
// Bench for alu_seq_w: directed cases plus random operations checked against an
// arithmetic reference model, with cycle-exact output timing checks.
module tb_alu_seq_w;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   s;
  logic [W-1:0] inbus;
  logic [W-1:0] outbus;
  logic         out_valid;
  logic         finish;
  logic         busy;
  logic         negative;
  logic         zero;
  logic         carry;
  logic         overflow;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  alu_seq_w #(.W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .s        (s),
    .inbus    (inbus),
    .outbus   (outbus),
    .out_valid(out_valid),
    .finish   (finish),
    .busy     (busy),
    .negative (negative),
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow)
  );

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         n;
    logic         z;
    logic         c;
    logic         v;
    logic         two;
  } res_t;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic res_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    res_t   r;
    longint ua, ub, sa, sb, x, smax, smin;
    r    = '0;
    ua   = longint'(a);
    ub   = longint'(b);
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -smax - 1;
    x    = 0;
    case (op)
      3'd0: begin
        x    = ua + ub;
        r.lo = W'(x);
        r.c  = (x >>> W) != 0;
        r.v  = (sa + sb > smax) || (sa + sb < smin);
      end
      3'd1, 3'd7: begin
        x    = ua - ub;
        r.lo = W'(x);
        r.c  = ua < ub;
        r.v  = (sa - sb > smax) || (sa - sb < smin);
      end
      3'd2: begin
        x     = sa * sb;
        r.lo  = W'(x);
        r.hi  = W'(x >>> W);
        r.v   = (x > smax) || (x < smin);
        r.two = 1'b1;
      end
      3'd3: begin
        r.two = 1'b1;
        if (ub == 0) begin
          r.lo = '1;
          r.hi = a;
          r.v  = 1'b1;
        end else begin
          r.lo = W'(ua / ub);
          r.hi = W'(ua % ub);
        end
      end
      3'd4: r.lo = a & b;
      3'd5: r.lo = a | b;
      default: r.lo = a ^ b;
    endcase
    if (op == 3'd2) begin
      r.n = x < 0;
      r.z = x == 0;
    end else begin
      r.n = r.lo[W-1];
      r.z = r.lo == '0;
    end
    if (op == 3'd7) r.lo = '0;
    return r;
  endfunction

  // Called #1 after an edge with the DUT idle; returns #1 after the finishing word's edge.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke, input bit gap);
    res_t        e;
    int unsigned lat;
    e   = model(op, a, b);
    lat = e.two ? W : 1;
    s     = op;
    start = 1'b1;
    @(posedge clk); #1;  // t
    start = 1'b0;
    s     = 3'($urandom);
    inbus = a;
    check_val("busy at t", busy, 1'b0);
    check_val("flags cleared at start", {negative, zero, carry, overflow}, 4'b0000);
    @(posedge clk); #1;  // t+1
    inbus = b;
    check_val("busy at t+1", busy, 1'b1);
    @(posedge clk); #1;  // t+2
    inbus = W'($urandom);
    for (int k = 3; k < 3 + int'(lat); k++) begin
      start = poke && (k == 4);
      @(posedge clk); #1;
      if (k == 2 + int'(lat)) check_val("no word before result", out_valid, 1'b0);
    end
    start = 1'b0;
    @(posedge clk); #1;  // t+3+lat
    check_val($sformatf("op%0d lo word", op), outbus, e.lo);
    check_val($sformatf("op%0d lo valid/finish", op), {out_valid, finish}, {1'b1, ~e.two});
    check_val($sformatf("op%0d NZCV", op), {negative, zero, carry, overflow},
              {e.n, e.z, e.c, e.v});
    if (e.two) begin
      @(posedge clk); #1;
      check_val($sformatf("op%0d hi word", op), outbus, e.hi);
      check_val($sformatf("op%0d hi valid/finish", op), {out_valid, finish, busy}, 3'b111);
    end
    if (gap) begin
      @(posedge clk); #1;
      check_val("idle outputs", {outbus, out_valid, finish, busy}, '0);
      check_val("flags held in idle", {negative, zero, carry, overflow}, {e.n, e.z, e.c, e.v});
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    s     = '0;
    inbus = '0;
    @(posedge clk); @(posedge clk); #1;
    check_val("reset state", {outbus, out_valid, finish, busy, negative, zero, carry, overflow},
              '0);
    rst = 1'b0;

    run_op(3'd0, 16'd2147, 16'd5, 1'b0, 1'b0);
    run_op(3'd0, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
    run_op(3'd1, 16'd5, 16'd2147, 1'b0, 1'b0);
    run_op(3'd1, 16'h8000, 16'h0001, 1'b0, 1'b0);
    run_op(3'd7, 16'd7, 16'd7, 1'b0, 1'b1);
    run_op(3'd2, 16'd2350, 16'd159, 1'b0, 1'b0);
    run_op(3'd2, 16'hFFFD, 16'd5, 1'b0, 1'b1);
    run_op(3'd3, 16'd18921, 16'd145, 1'b0, 1'b0);
    run_op(3'd3, 16'd100, 16'd0, 1'b0, 1'b1);
    run_op(3'd2, 16'h8000, 16'h8000, 1'b1, 1'b1);
    run_op(3'd4, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0);
    run_op(3'd6, 16'h5A5A, 16'h5A5A, 1'b0, 1'b1);

    // Reset partway through a DIV, then a fresh ADD.
    s     = 3'd3;
    start = 1'b1;
    @(posedge clk); #1;  // t
    start = 1'b0;
    inbus = 16'd1000;
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
      inbus = 16'd7;
    end
    check_val("busy during DIV", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;  // t+8
    rst = 1'b0;
    check_val("outputs after mid-op reset",
              {outbus, out_valid, finish, busy, negative, zero, carry, overflow}, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;  // t+10
    run_op(3'd0, 16'd1, 16'd1, 1'b0, 1'b1);

    // Reset and start together: start must be dropped.
    rst   = 1'b1;
    start = 1'b1;
    s     = 3'd0;
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("start dropped under reset", busy, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]   op;
      logic [W-1:0] a, b;
      op = 3'($urandom);
      a  = W'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      if (op == 3'd2 && $urandom_range(0, 1) == 1) b = W'($urandom_range(0, 15)) - 16'd8;
      run_op(op, a, b, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq_w.md
# alu_seq_w

Parametrised multi-cycle sequential ALU, the next-generation replacement for the fixed 16-bit start/finish ALU. Operands arrive serially on a shared `inbus`. The block runs one of eight operations, including a signed radix-2 Booth multiply and an unsigned restoring divide, each one iteration per clock. It returns one or two result words on `outbus`, qualified by `out_valid`/`finish`, and presents NZCV flags to the processor datapath and control unit.

## Interface
- `W`, 16, operand/result word width; legal range 4..64.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset: synchronous and active-high; one clock.
- `start`  in  1  operation request; sampled only in IDLE.
- `s`  in  3  opcode, sampled with `start`: 000 ADD, 001 SUB, 010 MUL (signed), 011 DIV (unsigned), 100 AND, 101 OR, 110 XOR, 111 CMP.
- `inbus`  in  W  operand input: A in the 1st cycle after start, B in the 2nd.
- `outbus`  out  W  result word; 0 whenever `out_valid`=0.
- `out_valid`  out  1  `outbus` holds a result word.
- `finish`  out  1  one-cycle pulse coinciding with the last result word.
- `busy`  out  1  high in every state except IDLE.
- `negative`, `zero`, `carry`, `overflow`  out  1 each  result flags.

## Operation
- FSM states: IDLE → LOAD_A → LOAD_B → EXEC → OUT_LO → (OUT_HI, MUL/DIV only) → IDLE.
- IDLE: when `start`=1, latch `s`, clear flags, go to LOAD_A.
  - `start` is ignored in all other states.
- LOAD_A: A ← `inbus`. LOAD_B: B ← `inbus`.
- EXEC duration:
  - 1 cycle for ADD/SUB/AND/OR/XOR/CMP.
  - Exactly W cycles for MUL/DIV, counted by an internal counter of $clog2(W)+1 bits.
  - No early exit, including divide-by-zero.
- ADD: R = A+B mod 2^W; C = carry-out; V = signed overflow.
- SUB/CMP: R = A−B mod 2^W; C = 1 on borrow (A<B unsigned); V = signed overflow.
  - CMP updates flags only; its OUT_LO word is 0.
- AND/OR/XOR: bitwise; C = V = 0.
- MUL: Booth radix-2 on a 2W+1 accumulator; product P is 2W-bit two's complement.
  - OUT_LO = P[W-1:0]; OUT_HI = P[2W-1:W].
  - V = 1 iff P is not representable in W signed bits; C = 0.
- DIV: restoring, unsigned.
  - OUT_LO = quotient; OUT_HI = remainder.
  - B = 0: quotient all-ones, remainder = A, V = 1.
  - Otherwise V = 0. C = 0 always.
- Flags:
  - N = MSB of the full result (P[2W-1] for MUL, quotient MSB for DIV).
  - Z = full result is zero (whole P for MUL; quotient for DIV).
  - Flags become valid when entering OUT_LO and hold until the next accepted `start`.
- Reset, including mid-operation:
  - FSM returns to IDLE; A, B, accumulator and counter clear.
  - All outputs read 0 from the cycle after `rst` is sampled.

## Timing
- `start` sampled at edge t: A captured at t+1, B at t+2, EXEC begins at t+3.
- Single-cycle ops: OUT_LO at t+4 with `out_valid`=`finish`=1; IDLE at t+5.
- MUL/DIV:
  - EXEC spans t+3..t+2+W.
  - OUT_LO at t+3+W: `out_valid`=1, `finish`=0.
  - OUT_HI at t+4+W: `out_valid`=`finish`=1.
  - IDLE at t+5+W. For W=16: words at t+19 and t+20.
- `busy` is high from t+1 through the last output cycle.
- Back-to-back: a new `start` is accepted in the first IDLE cycle after `finish`.
- `rst` and `start` asserted in the same cycle: reset wins and `start` is dropped.
- Reset values: `outbus`=0; `out_valid`, `finish`, `busy`, N, Z, C, V all 0.

## Test plan (W=16)
- ADD 2147+5 → OUT_LO 0x0868 at t+4 with `finish`; NZCV = 0000. Then ADD 0x7FFF+0x0001 → 0x8000; N=1, V=1, C=0.
- SUB 5−2147 → 0xF7A2; N=1, C=1, V=0. Then SUB 0x8000−1 → 0x7FFF; V=1. Then CMP 7,7 → `outbus`=0, Z=1.
- MUL 2350×159 → lo 0xB392 at t+19, hi 0x0005 at t+20 with `finish`; V=1. Then MUL −3×5 → 0xFFF1 / 0xFFFF; N=1, V=0.
- DIV 18921/145 → quotient 0x0082, remainder 0x0047; V=0. Then DIV 100/0 → 0xFFFF / 0x0064; V=1, both words at t+19/t+20.
- `start` pulsed during a MUL EXEC → ignored and the result is unchanged. AND 0xF0F0,0x0FF0 → 0x00F0. XOR of equal operands → 0; Z=1.
- `rst` at t+8 of a DIV → all outputs 0 at t+9, `busy`=0. A new ADD 1+1 started at t+11 → 0x0002 at t+15.
